// File: rtl/conv_pkg.sv
// Shared constants and types for the 1-D conv accelerator.
// OUTLEN is the length of one output vector (N-M+1).
package conv_pkg;
   localparam int T      = 16;
   localparam int P      = 2;
   localparam int N      = 96;
   localparam int M      = 65;
   localparam int OUTLEN = N - M + 1;

   typedef logic signed [T-1:0] data_t;
endpackage

// File: rtl/conv_y_serializer_if.sv
// Wide result input stream plus narrow y output stream.
// The master modport is the serializer side; slave is producer/consumer side.
interface conv_y_serializer_if;
   import conv_pkg::*;

   logic [P*T-1:0] in_data;
   logic           in_valid;
   logic           in_ready;
   data_t          y_data;
   logic           y_valid;
   logic           y_ready;
   logic           y_last;

   modport master (
      input  in_data, in_valid, y_ready,
      output in_ready, y_data, y_valid, y_last
   );

   modport slave (
      output in_data, in_valid, y_ready,
      input  in_ready, y_data, y_valid, y_last
   );
endinterface

// File: rtl/conv_wide_in_fifo.sv
// Circular buffer taking P entries per write and giving one per read.
// Ready/valid come from registered count only; reset masks both.
module conv_wide_in_fifo
   import conv_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [P*T-1:0] wr_data,
   input  logic           wr_valid,
   output logic           wr_ready,
   output data_t          rd_data,
   output logic           rd_valid,
   input  logic           rd_ready
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   data_t         mem_q [DEPTH];
   data_t         mem_d [DEPTH];
   logic          wr_acc;
   logic          rd_acc;

   assign wr_ready = !reset && (count_q <= CW'(DEPTH - P));
   assign rd_valid = !reset && (count_q != '0);
   assign rd_data  = mem_q[rd_ptr_q];

   always_comb begin
      wr_acc   = wr_valid && wr_ready;
      rd_acc   = rd_valid && rd_ready;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_acc) begin
         // lane p lands at wr_ptr+p; the AW-bit sum wraps naturally
         for (int p = 0; p < P; p++) begin
            mem_d[wr_ptr_q + AW'(p)] = wr_data[p*T +: T];
         end
         wr_ptr_d = wr_ptr_q + AW'(P);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q
              + (wr_acc ? CW'(P) : '0)
              - (rd_acc ? CW'(1) : '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/conv_y_serializer.sv
// y stream transmitter: buffers P-wide results and emits one value per
// handshake, flagging the last element of each OUTLEN-long vector.
module conv_y_serializer
   import conv_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   conv_y_serializer_if.master bus
);
   localparam int VW = $clog2(OUTLEN);

   logic [VW-1:0] vec_idx_q, vec_idx_d;
   data_t         y_data;
   logic          y_valid;
   logic          in_ready;
   logic          y_acc;
   logic          at_last;

   conv_wide_in_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_data  (bus.in_data),
      .wr_valid (bus.in_valid),
      .wr_ready (in_ready),
      .rd_data  (y_data),
      .rd_valid (y_valid),
      .rd_ready (bus.y_ready)
   );

   always_comb begin
      y_acc     = y_valid && bus.y_ready;
      at_last   = (vec_idx_q == VW'(OUTLEN - 1));
      vec_idx_d = vec_idx_q;
      if (y_acc) begin
         vec_idx_d = at_last ? '0 : vec_idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vec_idx_q <= '0;
      end else begin
         vec_idx_q <= vec_idx_d;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.y_data   = y_data;
   assign bus.y_valid  = y_valid;
   assign bus.y_last   = y_valid && at_last;
endmodule

// File: tb/tb_conv_y_serializer.sv
// Directed and random checks of conv_y_serializer against a queue model.
module tb_conv_y_serializer;
   import conv_pkg::*;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset;
   int         total = 0;
   int         bad = 0;
   logic [T-1:0] q[$];
   int         out_idx;
   int         in_beats;
   int         nlast;
   int         n0;
   bit         last_chk;
   logic       held_v;
   logic [T-1:0] held_d;
   logic       held_l;

   conv_y_serializer_if bus ();

   conv_y_serializer #(
      .DEPTH(DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // one clock: observe at negedge, return 1 after posedge
   task automatic cyc();
      logic [T-1:0] v;
      @(negedge clk);
      if (reset) begin
         q.delete();
         out_idx = 0;
         held_v  = 1'b0;
      end else begin
         if (held_v) begin
            check("hold_valid", bus.y_valid, 1);
            check("hold_data", {16'd0, bus.y_data}, {16'd0, held_d});
            check("hold_last", bus.y_last, held_l);
         end
         check("y_valid", bus.y_valid, q.size() != 0);
         check("in_ready", bus.in_ready, q.size() <= DEPTH - P);
         if (bus.y_valid && q.size() != 0) begin
            check("y_data", {16'd0, bus.y_data}, {16'd0, q[0]});
            check("y_last", bus.y_last, out_idx == OUTLEN - 1);
         end
         held_v = bus.y_valid && !bus.y_ready;
         held_d = bus.y_data;
         held_l = bus.y_last;
         if (bus.y_valid && bus.y_ready && q.size() != 0) begin
            v = q.pop_front();
            if (last_chk) check("last_val", bus.y_last, v == 31 || v == 63);
            if (bus.y_last) nlast++;
            out_idx = (out_idx == OUTLEN - 1) ? 0 : out_idx + 1;
         end
         if (bus.in_valid && bus.in_ready) begin
            for (int p = 0; p < P; p++) q.push_back(bus.in_data[p*T +: T]);
            in_beats++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bus.in_valid = 1'b0;
      bus.y_ready  = 1'b1;
      for (int i = 0; i < 40 && (q.size() != 0 || bus.y_valid); i++) cyc();
      check("drain", q.size() == 0 && !bus.y_valid, 1);
   endtask

   initial begin
      q.delete();
      out_idx  = 0;
      in_beats = 0;
      nlast    = 0;
      held_v   = 1'b0;
      held_d   = '0;
      held_l   = 1'b0;
      last_chk = 1'b0;

      // reset with a pending input beat
      reset        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = {16'hBBBB, 16'hAAAA};
      bus.y_ready  = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_y_valid", bus.y_valid, 0);
      check("rst_y_last", bus.y_last, 0);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_y_valid", bus.y_valid, 0);

      // ordering and first-value latency
      bus.in_valid = 1'b1;
      bus.in_data  = {16'h0002, 16'h0001};
      cyc();
      check("lat_valid", bus.y_valid, 1);
      check("lat_data", {16'd0, bus.y_data}, 32'h1);
      bus.in_data = {16'h0004, 16'h0003};
      cyc();
      drain();

      // fill to DEPTH with the consumer stalled
      bus.y_ready  = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_data = {16'(16 + 2*i + 1), 16'(16 + 2*i)};
         cyc();
      end
      check("full_in_ready", bus.in_ready, 0);
      bus.in_data = {16'h0019, 16'h0018};
      cyc();
      cyc();
      check("full_hold", bus.in_ready, 0);
      bus.y_ready = 1'b1;
      cyc();
      bus.y_ready = 1'b0;
      check("cnt7_in_ready", bus.in_ready, 0);
      bus.y_ready = 1'b1;
      cyc();
      check("cnt6_in_ready", bus.in_ready, 1);
      cyc();
      drain();

      // pointer wrap with simultaneous accepts
      n0 = in_beats;
      bus.y_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = {16'(100 + 2*i + 1), 16'(100 + 2*i)};
         cyc();
         bus.in_valid = 1'b0;
         cyc();
      end
      check("wrap_beats", in_beats - n0, 20);
      drain();

      // reset with data buffered
      bus.y_ready  = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = {16'h7777, 16'h6666};
      cyc();
      cyc();
      cyc();
      reset = 1'b1;
      #1;
      check("mid_rst_y_valid", bus.y_valid, 0);
      check("mid_rst_in_ready", bus.in_ready, 0);
      cyc();
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("mid_post_y_valid", bus.y_valid, 0);

      // values 0..63: y_last on 31 and 63 only
      last_chk    = 1'b1;
      nlast       = 0;
      n0          = in_beats;
      bus.y_ready = 1'b1;
      for (int c = 0; c < 400 && in_beats - n0 < 32; c++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = {16'(2*(in_beats - n0) + 1), 16'(2*(in_beats - n0))};
         cyc();
      end
      drain();
      last_chk = 1'b0;
      check("last_count", nlast, 2);

      // random handshakes, 104 full vectors
      nlast = 0;
      n0    = in_beats;
      for (int c = 0; c < 30000 && in_beats - n0 < 1664; c++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.y_ready  = 1'($urandom_range(0, 1));
         bus.in_data  = {16'($urandom), 16'($urandom)};
         cyc();
      end
      check("rand_beats", in_beats - n0, 1664);
      drain();
      check("rand_vectors", nlast, 104);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
